pio_out_fifo: RTL and testbench

PIO_OUT_FIFO -- requirements
Module: pio_out_fifo

---
 rtl/pio_out_fifo.sv | 102 ++++++++++
 tb/tb_pio_out_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_out_fifo.sv
// Output-side FIFO for the PIO block: registered head word, count-based full/empty,
// flush, and a sticky flag for writers that drop or change a stalled word.
module pio_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         hold_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             hold_err_q, hold_err_d;
  logic             stall_q, stall_d;
  logic [WIDTH-1:0] stall_data_q, stall_data_d;
  logic             wr_en, rd_en;

  // in_ready looks only at the stored count, so a full queue never takes a word
  // even when the reader frees a slot on the same edge.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign hold_err  = hold_err_q;

  assign wr_en = in_valid & in_ready & ~flush;
  assign rd_en = out_valid & out_ready & ~flush;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = in_data;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hold_err_d   = hold_err_q;
    stall_d      = in_valid & ~in_ready;
    stall_data_d = in_data;

    // A stalled word must be re-offered unchanged on the following edge.
    if (stall_q && (!in_valid || (in_data != stall_data_q))) hold_err_d = 1'b1;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      hold_err_d = 1'b0;
      stall_d    = 1'b0;
    end
  end

  // Storage is not reset; out_data masking keeps stale entries invisible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_err_q   <= 1'b0;
      stall_q      <= 1'b0;
      stall_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_err_q   <= hold_err_d;
      stall_q      <= stall_d;
      stall_data_q <= stall_data_d;
    end
  end

endmodule

// File: tb/tb_pio_out_fifo.sv
// Bench for pio_out_fifo: queue-based model checked every cycle on the default
// instance, plus directed literal checks on a 16-bit, 8-deep instance.
module tb_pio_out_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance (WIDTH=8, DEPTH=4)
  logic       a_rst = 1'b0, a_iv = 1'b0, a_fl = 1'b0, a_or = 1'b0;
  logic [7:0] a_id = '0;
  logic [7:0] a_od;
  logic       a_ir, a_ov, a_he;
  logic [2:0] a_cnt;

  pio_out_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_id), .in_valid(a_iv), .in_ready(a_ir),
    .flush(a_fl), .out_data(a_od), .out_valid(a_ov), .out_ready(a_or),
    .count(a_cnt), .hold_err(a_he)
  );

  // Wide instance (WIDTH=16, DEPTH=8)
  logic        b_rst = 1'b0, b_iv = 1'b0, b_fl = 1'b0, b_or = 1'b0;
  logic [15:0] b_id = '0;
  logic [15:0] b_od;
  logic        b_ir, b_ov, b_he;
  logic [3:0]  b_cnt;

  pio_out_fifo #(.WIDTH(16), .DEPTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_id), .in_valid(b_iv), .in_ready(b_ir),
    .flush(b_fl), .out_data(b_od), .out_valid(b_ov), .out_ready(b_or),
    .count(b_cnt), .hold_err(b_he)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: a plain queue of words plus protocol memory.
  logic [7:0] mq[$];
  bit         m_herr = 1'b0;
  bit         m_stall = 1'b0;
  logic [7:0] m_sdata = '0;
  bit         started = 1'b0;

  always @(posedge clk) begin
    bit rdy, vld;
    if (!a_rst || a_fl) begin
      mq.delete();
      m_herr  = 1'b0;
      m_stall = 1'b0;
    end else begin
      rdy = (mq.size() != 4);
      vld = (mq.size() != 0);
      if (m_stall && (!a_iv || a_id != m_sdata)) m_herr = 1'b1;
      m_stall = a_iv && !rdy;
      m_sdata = a_id;
      if (vld && a_or) void'(mq.pop_front());
      if (a_iv && rdy) mq.push_back(a_id);
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("count",     64'(a_cnt), 64'(mq.size()));
      chk("in_ready",  64'(a_ir),  64'(mq.size() != 4));
      chk("out_valid", 64'(a_ov),  64'(mq.size() != 0));
      chk("out_data",  64'(a_od),  (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
      chk("hold_err",  64'(a_he),  64'(m_herr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] d);
    a_iv = 1'b1; a_id = d; tick(); a_iv = 1'b0;
  endtask

  initial begin
    // Reset both instances
    a_rst = 1'b0; b_rst = 1'b0;
    tick(); tick();
    a_rst = 1'b1;
    chk("a_reset_count", 64'(a_cnt), 64'd0);
    chk("a_reset_in_ready", 64'(a_ir), 64'd1);
    chk("a_reset_out_data", 64'(a_od), 64'd0);

    // Fill with out_ready low
    a_write(8'h11);
    chk("a_fill_cnt1", 64'(a_cnt), 64'd1);
    chk("a_latency_ov", 64'(a_ov), 64'd1);
    chk("a_latency_od", 64'(a_od), 64'h11);
    a_write(8'h22); chk("a_fill_cnt2", 64'(a_cnt), 64'd2);
    a_write(8'h33); chk("a_fill_cnt3", 64'(a_cnt), 64'd3);
    a_write(8'h44); chk("a_fill_cnt4", 64'(a_cnt), 64'd4);
    chk("a_full_in_ready", 64'(a_ir), 64'd0);
    chk("a_full_od", 64'(a_od), 64'h11);
    chk("model_size_full", 64'(mq.size()), 64'd4);
    chk("model_head_full", 64'(mq[0]), 64'h11);

    // Full queue: simultaneous read does not open a write slot
    a_iv = 1'b1; a_id = 8'h55; a_or = 1'b1; tick();
    chk("a_fullrd_cnt", 64'(a_cnt), 64'd3);
    chk("a_fullrd_od", 64'(a_od), 64'h22);
    a_or = 1'b0; tick();
    chk("a_accept55_cnt", 64'(a_cnt), 64'd4);
    chk("model_tail55", 64'(mq[3]), 64'h55);
    a_iv = 1'b0;

    // Drain to one word, then stream 256 words at count=1
    a_or = 1'b1; tick(); tick(); tick();
    chk("a_drain_od", 64'(a_od), 64'h55);
    for (int i = 0; i < 256; i++) begin
      a_iv = 1'b1; a_id = 8'(i); tick();
      chk("a_stream_cnt", 64'(a_cnt), 64'd1);
      chk("a_stream_od", 64'(a_od), 64'(i));
    end
    a_iv = 1'b0; a_or = 1'b0;

    // Flush collision at count=3
    a_write(8'h10); a_write(8'h20);
    chk("a_pre_flush_cnt", 64'(a_cnt), 64'd3);
    a_fl = 1'b1; a_iv = 1'b1; a_id = 8'hEE; a_or = 1'b1; tick();
    a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0;
    chk("a_flush_cnt", 64'(a_cnt), 64'd0);
    chk("a_flush_ov", 64'(a_ov), 64'd0);
    chk("a_flush_od", 64'(a_od), 64'd0);
    a_write(8'h01);
    chk("a_post_flush_od", 64'(a_od), 64'h01);
    a_or = 1'b1; tick(); a_or = 1'b0;
    chk("a_post_flush_empty", 64'(a_cnt), 64'd0);

    // Protocol violation: stalled word changes
    a_write(8'hC1); a_write(8'hC2); a_write(8'hC3); a_write(8'hC4);
    a_iv = 1'b1; a_id = 8'hA5; tick();
    chk("a_stall_no_err", 64'(a_he), 64'd0);
    a_id = 8'h5A; tick();
    a_iv = 1'b0;
    chk("a_viol_err", 64'(a_he), 64'd1);
    tick(); tick(); tick();
    chk("a_viol_sticky", 64'(a_he), 64'd1);
    a_fl = 1'b1; tick(); a_fl = 1'b0;
    chk("a_flush_clears_err", 64'(a_he), 64'd0);

    // Violation by dropping in_valid, then reset at count=2
    a_write(8'hD1); a_write(8'hD2); a_write(8'hD3); a_write(8'hD4);
    a_iv = 1'b1; a_id = 8'hA5; tick(); a_iv = 1'b0; tick();
    chk("a_drop_err", 64'(a_he), 64'd1);
    a_or = 1'b1; tick(); tick(); a_or = 1'b0;
    chk("a_pre_rst_cnt", 64'(a_cnt), 64'd2);
    chk("a_pre_rst_err", 64'(a_he), 64'd1);
    a_rst = 1'b0; tick(); a_rst = 1'b1;
    chk("a_rst_cnt", 64'(a_cnt), 64'd0);
    chk("a_rst_ov", 64'(a_ov), 64'd0);
    chk("a_rst_od", 64'(a_od), 64'd0);
    chk("a_rst_err", 64'(a_he), 64'd0);
    chk("a_rst_ir", 64'(a_ir), 64'd1);
    a_write(8'h7E);
    chk("a_rst_first_word", 64'(a_od), 64'h7E);
    a_or = 1'b1; tick(); a_or = 1'b0;

    // Wide instance: same reset scenario at WIDTH=16, DEPTH=8
    b_rst = 1'b1;
    chk("b_reset_cnt", 64'(b_cnt), 64'd0);
    for (int i = 0; i < 8; i++) begin
      b_iv = 1'b1; b_id = 16'h1000 + 16'(i); tick();
    end
    chk("b_full_cnt", 64'(b_cnt), 64'd8);
    chk("b_full_ir", 64'(b_ir), 64'd0);
    chk("b_full_od", 64'(b_od), 64'h1000);
    b_id = 16'hA5A5; tick();
    b_id = 16'h5A5A; tick();
    b_iv = 1'b0;
    chk("b_viol_err", 64'(b_he), 64'd1);
    b_or = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    b_or = 1'b0;
    chk("b_pre_rst_cnt", 64'(b_cnt), 64'd2);
    chk("b_pre_rst_od", 64'(b_od), 64'h1006);
    chk("b_pre_rst_err", 64'(b_he), 64'd1);
    b_rst = 1'b0; tick(); b_rst = 1'b1;
    chk("b_rst_cnt", 64'(b_cnt), 64'd0);
    chk("b_rst_ov", 64'(b_ov), 64'd0);
    chk("b_rst_od", 64'(b_od), 64'd0);
    chk("b_rst_err", 64'(b_he), 64'd0);
    chk("b_rst_ir", 64'(b_ir), 64'd1);
    b_iv = 1'b1; b_id = 16'h007E; tick(); b_iv = 1'b0;
    chk("b_rst_first_word", 64'(b_od), 64'h007E);
    b_or = 1'b1; tick(); b_or = 1'b0;
    chk("b_final_cnt", 64'(b_cnt), 64'd0);

    // Randomized traffic on instance A, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      rd_pct = ((i / 500) % 2 == 0) ? 3 : 7;
      a_rst = ($urandom_range(0, 199) != 0);
      a_fl  = ($urandom_range(0, 39) == 0);
      a_iv  = ($urandom_range(0, 9) < 6);
      a_or  = ($urandom_range(0, 9) < rd_pct);
      if ($urandom_range(0, 1) == 1) a_id = 8'($urandom);
      tick();
    end
    a_rst = 1'b1; a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
